// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with MEM/WB operand bypass, ALU operand select and
// load-use bubble insertion for the EX stage.
module ex_operand_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_pc,
  input  logic [WIDTH-1:0] in_rsData,
  input  logic [WIDTH-1:0] in_rtData,
  input  logic [WIDTH-1:0] in_imm,
  input  logic [4:0]       in_shamt,
  input  logic [RADDR-1:0] in_rs,
  input  logic [RADDR-1:0] in_rt,
  input  logic [RADDR-1:0] in_dest,
  input  logic             in_useRs,
  input  logic             in_useRt,
  input  logic [3:0]       in_aluOp,
  input  logic             in_aluSrcImm,
  input  logic             in_shiftShamt,
  input  logic             in_shiftReg,
  input  logic             in_regWrite,
  input  logic             in_memRead,
  input  logic             in_memWrite,
  input  logic             mem_regWrite,
  input  logic [RADDR-1:0] mem_dest,
  input  logic [WIDTH-1:0] mem_result,
  input  logic             wb_regWrite,
  input  logic [RADDR-1:0] wb_dest,
  input  logic [WIDTH-1:0] wb_result,
  output logic [WIDTH-1:0] aluA,
  output logic [WIDTH-1:0] aluB,
  output logic [3:0]       aluOp,
  output logic [WIDTH-1:0] storeData,
  output logic             ex_valid,
  output logic             ex_regWrite,
  output logic             ex_memRead,
  output logic             ex_memWrite,
  output logic [RADDR-1:0] ex_dest,
  output logic [WIDTH-1:0] ex_pc,
  output logic             loadUseHazard
);

  localparam logic [3:0] ALU_ADD = 4'h0;

  logic             valid_q, regwrite_q, memread_q, memwrite_q;
  logic [RADDR-1:0] dest_q, rs_q, rt_q;
  logic [WIDTH-1:0] pc_q, rs_data_q, rt_data_q, imm_q;
  logic [4:0]       shamt_q;
  logic [3:0]       aluop_q;
  logic             alusrcimm_q, shiftshamt_q, shiftreg_q;
  logic [WIDTH-1:0] rs_fwd_s, rt_fwd_s;
  logic             hazard_s;

  // MEM beats WB; register 0 is hard-wired and never bypassed.
  function automatic logic [WIDTH-1:0] fwd_value(
    input logic [RADDR-1:0] idx,
    input logic [WIDTH-1:0] stored,
    input logic             m_we,
    input logic [RADDR-1:0] m_dst,
    input logic [WIDTH-1:0] m_res,
    input logic             w_we,
    input logic [RADDR-1:0] w_dst,
    input logic [WIDTH-1:0] w_res
  );
    logic [WIDTH-1:0] v;
    if (m_we && (m_dst != {RADDR{1'b0}}) && (m_dst == idx)) begin
      v = m_res;
    end else if (w_we && (w_dst != {RADDR{1'b0}}) && (w_dst == idx)) begin
      v = w_res;
    end else begin
      v = stored;
    end
    return v;
  endfunction

  always_comb begin
    rs_fwd_s = fwd_value(rs_q, rs_data_q, mem_regWrite, mem_dest, mem_result,
                         wb_regWrite, wb_dest, wb_result);
    rt_fwd_s = fwd_value(rt_q, rt_data_q, mem_regWrite, mem_dest, mem_result,
                         wb_regWrite, wb_dest, wb_result);
    hazard_s = valid_q && memread_q && (dest_q != {RADDR{1'b0}}) && in_valid &&
               ((in_useRs && (in_rs == dest_q)) || (in_useRt && (in_rt == dest_q)));
  end

  // shiftShamt takes precedence if decode ever raises both shift selects.
  always_comb begin
    aluA = rs_fwd_s;
    aluB = rt_fwd_s;
    if (shiftshamt_q) begin
      aluA = {{(WIDTH-5){1'b0}}, shamt_q};
    end else if (shiftreg_q) begin
      aluA = {{(WIDTH-5){1'b0}}, rs_fwd_s[4:0]};
    end else begin
      aluA = rs_fwd_s;
    end
    if (alusrcimm_q && !shiftshamt_q && !shiftreg_q) begin
      aluB = imm_q;
    end else begin
      aluB = rt_fwd_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush || (!stall && hazard_s)) begin
      if (!rst_n || flush || hazard_s) begin
        valid_q      <= 1'b0;
        regwrite_q   <= 1'b0;
        memread_q    <= 1'b0;
        memwrite_q   <= 1'b0;
        dest_q       <= {RADDR{1'b0}};
        rs_q         <= {RADDR{1'b0}};
        rt_q         <= {RADDR{1'b0}};
        pc_q         <= {WIDTH{1'b0}};
        rs_data_q    <= {WIDTH{1'b0}};
        rt_data_q    <= {WIDTH{1'b0}};
        imm_q        <= {WIDTH{1'b0}};
        shamt_q      <= 5'd0;
        aluop_q      <= ALU_ADD;
        alusrcimm_q  <= 1'b0;
        shiftshamt_q <= 1'b0;
        shiftreg_q   <= 1'b0;
      end else begin
        valid_q <= 1'b0;
      end
    end else if (stall) begin
      // Capture bypass values so a writer retiring during the hold is not lost.
      rs_data_q <= rs_fwd_s;
      rt_data_q <= rt_fwd_s;
    end else begin
      valid_q      <= in_valid;
      regwrite_q   <= in_regWrite;
      memread_q    <= in_memRead;
      memwrite_q   <= in_memWrite;
      dest_q       <= in_dest;
      rs_q         <= in_rs;
      rt_q         <= in_rt;
      pc_q         <= in_pc;
      rs_data_q    <= in_rsData;
      rt_data_q    <= in_rtData;
      imm_q        <= in_imm;
      shamt_q      <= in_shamt;
      aluop_q      <= in_aluOp;
      alusrcimm_q  <= in_aluSrcImm;
      shiftshamt_q <= in_shiftShamt;
      shiftreg_q   <= in_shiftReg;
    end
  end

  assign aluOp         = aluop_q;
  assign storeData     = rt_fwd_s;
  assign ex_valid      = valid_q;
  assign ex_regWrite   = regwrite_q;
  assign ex_memRead    = memread_q;
  assign ex_memWrite   = memwrite_q;
  assign ex_dest       = dest_q;
  assign ex_pc         = pc_q;
  assign loadUseHazard = hazard_s;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Randomized bench for ex_operand_stage with an instruction-level reference
// model plus a directed sequence pinning hand-computed values.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, in_valid;
  logic [31:0] in_pc, in_rsData, in_rtData, in_imm;
  logic [4:0]  in_shamt, in_rs, in_rt, in_dest;
  logic        in_useRs, in_useRt, in_aluSrcImm, in_shiftShamt, in_shiftReg;
  logic [3:0]  in_aluOp;
  logic        in_regWrite, in_memRead, in_memWrite;
  logic        mem_regWrite, wb_regWrite;
  logic [4:0]  mem_dest, wb_dest;
  logic [31:0] mem_result, wb_result;
  logic [31:0] aluA, aluB, storeData, ex_pc;
  logic [3:0]  aluOp;
  logic        ex_valid, ex_regWrite, ex_memRead, ex_memWrite, loadUseHazard;
  logic [4:0]  ex_dest;

  int n_cmp  = 0;
  int n_fail = 0;

  ex_operand_stage #(.WIDTH(32), .RADDR(5)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_rsData(in_rsData),
    .in_rtData(in_rtData), .in_imm(in_imm), .in_shamt(in_shamt),
    .in_rs(in_rs), .in_rt(in_rt), .in_dest(in_dest),
    .in_useRs(in_useRs), .in_useRt(in_useRt), .in_aluOp(in_aluOp),
    .in_aluSrcImm(in_aluSrcImm), .in_shiftShamt(in_shiftShamt),
    .in_shiftReg(in_shiftReg), .in_regWrite(in_regWrite),
    .in_memRead(in_memRead), .in_memWrite(in_memWrite),
    .mem_regWrite(mem_regWrite), .mem_dest(mem_dest), .mem_result(mem_result),
    .wb_regWrite(wb_regWrite), .wb_dest(wb_dest), .wb_result(wb_result),
    .aluA(aluA), .aluB(aluB), .aluOp(aluOp), .storeData(storeData),
    .ex_valid(ex_valid), .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead),
    .ex_memWrite(ex_memWrite), .ex_dest(ex_dest), .ex_pc(ex_pc),
    .loadUseHazard(loadUseHazard)
  );

  always #5 clk = ~clk;

  // The instruction currently sitting in EX, as the model sees it.
  typedef struct {
    logic        valid, regWrite, memRead, memWrite, srcImm, shSh, shReg;
    logic [4:0]  dest, rs, rt, shamt;
    logic [31:0] pc, rsData, rtData, imm;
    logic [3:0]  op;
  } ex_t;

  ex_t m;

  function automatic ex_t bubble();
    ex_t b;
    b.valid = 1'b0; b.regWrite = 1'b0; b.memRead = 1'b0; b.memWrite = 1'b0;
    b.srcImm = 1'b0; b.shSh = 1'b0; b.shReg = 1'b0;
    b.dest = 5'd0; b.rs = 5'd0; b.rt = 5'd0; b.shamt = 5'd0;
    b.pc = 32'd0; b.rsData = 32'd0; b.rtData = 32'd0; b.imm = 32'd0;
    b.op = 4'h0;
    return b;
  endfunction

  function automatic logic [31:0] reg_value(input logic [4:0] idx, input logic [31:0] stored);
    if (idx != 5'd0 && mem_regWrite && mem_dest == idx) return mem_result;
    if (idx != 5'd0 && wb_regWrite && wb_dest == idx) return wb_result;
    return stored;
  endfunction

  function automatic logic model_hazard();
    return m.valid && m.memRead && m.dest != 5'd0 && in_valid &&
           ((in_useRs && in_rs == m.dest) || (in_useRt && in_rt == m.dest));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [31:0] a, b, rsv, rtv;
    rsv = reg_value(m.rs, m.rsData);
    rtv = reg_value(m.rt, m.rtData);
    a = m.shSh ? {27'd0, m.shamt} : (m.shReg ? (rsv & 32'h1F) : rsv);
    b = (m.srcImm && !m.shSh && !m.shReg) ? m.imm : rtv;
    chk("aluA", aluA, a);
    chk("aluB", aluB, b);
    chk("storeData", storeData, rtv);
    chk("aluOp", {28'd0, aluOp}, {28'd0, m.op});
    chk("ctrl", {28'd0, ex_valid, ex_regWrite, ex_memRead, ex_memWrite},
        {28'd0, m.valid, m.regWrite, m.memRead, m.memWrite});
    chk("ex_dest", {27'd0, ex_dest}, {27'd0, m.dest});
    chk("ex_pc", ex_pc, m.pc);
    chk("loadUseHazard", {31'd0, loadUseHazard}, {31'd0, model_hazard()});
  endtask

  task automatic model_edge();
    ex_t n;
    if (!rst_n || flush) begin
      n = bubble();
    end else if (stall) begin
      n = m;
      n.rsData = reg_value(m.rs, m.rsData);
      n.rtData = reg_value(m.rt, m.rtData);
    end else if (model_hazard()) begin
      n = bubble();
    end else begin
      n.valid = in_valid; n.regWrite = in_regWrite; n.memRead = in_memRead;
      n.memWrite = in_memWrite; n.srcImm = in_aluSrcImm; n.shSh = in_shiftShamt;
      n.shReg = in_shiftReg; n.dest = in_dest; n.rs = in_rs; n.rt = in_rt;
      n.shamt = in_shamt; n.pc = in_pc; n.rsData = in_rsData; n.rtData = in_rtData;
      n.imm = in_imm; n.op = in_aluOp;
    end
    m = n;
  endtask

  // Check at negedge, advance model on posedge, return just after the edge.
  task automatic step();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic clear_inputs();
    stall = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = 32'd0;
    in_rsData = 32'd0; in_rtData = 32'd0; in_imm = 32'd0; in_shamt = 5'd0;
    in_rs = 5'd0; in_rt = 5'd0; in_dest = 5'd0; in_useRs = 1'b0; in_useRt = 1'b0;
    in_aluOp = 4'h0; in_aluSrcImm = 1'b0; in_shiftShamt = 1'b0; in_shiftReg = 1'b0;
    in_regWrite = 1'b0; in_memRead = 1'b0; in_memWrite = 1'b0;
    mem_regWrite = 1'b0; mem_dest = 5'd0; mem_result = 32'd0;
    wb_regWrite = 1'b0; wb_dest = 5'd0; wb_result = 32'd0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    m = bubble();
    #12;
    chk("rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_aluOp", {28'd0, aluOp}, 32'd0);
    chk("rst_aluA", aluA, 32'd0);
    chk("rst_aluB", aluB, 32'd0);
    rst_n = 1'b1;
    step();

    // add r3 = r1 + r2
    in_valid = 1'b1; in_pc = 32'h100; in_rs = 5'd1; in_rt = 5'd2; in_dest = 5'd3;
    in_rsData = 32'h5; in_rtData = 32'h7; in_useRs = 1'b1; in_useRt = 1'b1;
    in_regWrite = 1'b1;
    step();
    chk("add_aluA", aluA, 32'h5);
    chk("add_aluB", aluB, 32'h7);
    chk("add_dest", {27'd0, ex_dest}, 32'd3);
    chk("add_regWrite", {31'd0, ex_regWrite}, 32'd1);
    mem_regWrite = 1'b1; mem_dest = 5'd1; mem_result = 32'hA;
    wb_regWrite = 1'b1; wb_dest = 5'd1; wb_result = 32'hB;
    #1 chk("fwd_mem", aluA, 32'hA);
    mem_regWrite = 1'b0;
    #1 chk("fwd_wb", aluA, 32'hB);
    mem_regWrite = 1'b1; mem_dest = 5'd0; wb_dest = 5'd0;
    #1 chk("fwd_r0", aluA, 32'h5);
    mem_regWrite = 1'b0; wb_regWrite = 1'b0;

    // sll by shamt 4, then sllv using rs low bits
    in_rs = 5'd0; in_useRs = 1'b0; in_rtData = 32'h1; in_shiftShamt = 1'b1;
    in_shamt = 5'd4; in_aluOp = 4'h2;
    step();
    chk("sll_aluA", aluA, 32'h4);
    chk("sll_aluB", aluB, 32'h1);
    in_shiftShamt = 1'b0; in_shiftReg = 1'b1; in_rs = 5'd1; in_useRs = 1'b1;
    in_rsData = 32'hFFFFFF23;
    step();
    chk("sllv_aluA", aluA, 32'h3);
    chk("sllv_aluB", aluB, 32'h1);

    // lw r5, then dependent add
    in_shiftReg = 1'b0; in_aluOp = 4'h0; in_memRead = 1'b1; in_dest = 5'd5;
    in_aluSrcImm = 1'b1; in_imm = 32'h8; in_useRt = 1'b0;
    step();
    in_memRead = 1'b0; in_aluSrcImm = 1'b0; in_rs = 5'd5; in_rt = 5'd2;
    in_useRt = 1'b1; in_dest = 5'd6; in_rsData = 32'h11; in_rtData = 32'h7;
    #1 chk("lu_hazard", {31'd0, loadUseHazard}, 32'd1);
    step();
    chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_bubble_rw", {31'd0, ex_regWrite}, 32'd0);
    chk("lu_hazard_gone", {31'd0, loadUseHazard}, 32'd0);
    step();
    chk("lu_loaded_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_loaded_dest", {27'd0, ex_dest}, 32'd6);

    // stall while WB retires r2 for one cycle only
    stall = 1'b1; wb_regWrite = 1'b1; wb_dest = 5'd2; wb_result = 32'h99;
    step();
    wb_regWrite = 1'b0;
    step();
    stall = 1'b0; in_valid = 1'b0;
    #1 chk("stall_aluB", aluB, 32'h99);
    chk("stall_store", storeData, 32'h99);
    stall = 1'b1; flush = 1'b1; in_valid = 1'b1;
    step();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_aluA", aluA, 32'd0);

    // reset in the middle of a stall
    flush = 1'b0; stall = 1'b0;
    step();
    stall = 1'b1;
    #1 rst_n = 1'b0;
    m = bubble();
    #1 chk("midrst_valid", {31'd0, ex_valid}, 32'd0);
    chk("midrst_aluA", aluA, 32'd0);
    step();
    rst_n = 1'b1;
    stall = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      stall         = ($urandom_range(0, 4) == 0);
      flush         = ($urandom_range(0, 9) == 0);
      in_valid      = ($urandom_range(0, 3) != 0);
      in_pc         = $urandom;
      in_rsData     = $urandom;
      in_rtData     = $urandom;
      in_imm        = $urandom;
      in_shamt      = 5'($urandom);
      in_rs         = 5'($urandom_range(0, 5));
      in_rt         = 5'($urandom_range(0, 5));
      in_dest       = 5'($urandom_range(0, 5));
      in_useRs      = 1'($urandom);
      in_useRt      = 1'($urandom);
      in_aluOp      = 4'($urandom);
      in_aluSrcImm  = 1'($urandom);
      in_shiftShamt = ($urandom_range(0, 3) == 0);
      in_shiftReg   = ($urandom_range(0, 3) == 0);
      in_regWrite   = 1'($urandom);
      in_memRead    = ($urandom_range(0, 2) == 0);
      in_memWrite   = 1'($urandom);
      mem_regWrite  = 1'($urandom);
      mem_dest      = 5'($urandom_range(0, 5));
      mem_result    = $urandom;
      wb_regWrite   = 1'($urandom);
      wb_dest       = 5'($urandom_range(0, 5));
      wb_result     = $urandom;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_operand_stage.md
Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus the operand-select and forwarding logic for the EX-stage ALU.
- Captures decoded instructions from ID and holds them in EX.
- Each cycle it resolves operand sources (MEM/WB bypass, immediate, shamt) and drives the ALU's A, B and operation inputs.
- Detects load-use hazards and inserts a bubble on its own; MEM stage consumes the register/control outputs.

Parameters:
- WIDTH, 32, datapath width.
- RADDR, 5, register-index width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold EX contents (downstream backpressure)
- flush  in  1  load bubble next edge (branch/exception)
- in_valid  in  1  ID holds a real instruction
- in_pc  in  WIDTH  instruction PC
- in_rsData, in_rtData  in  WIDTH  register-file read data
- in_imm  in  WIDTH  extended immediate
- in_shamt  in  5  shift amount field
- in_rs, in_rt, in_dest  in  RADDR  source and destination indices
- in_useRs, in_useRt  in  1  instruction reads rs/rt
- in_aluOp  in  4  ALU operation code (define.vh encoding)
- in_aluSrcImm  in  1  B operand is in_imm
- in_shiftShamt  in  1  A operand is shamt
- in_shiftReg  in  1  A operand is rs[4:0]
- in_regWrite, in_memRead, in_memWrite  in  1  control bits
- mem_regWrite  in  1  MEM-stage write enable
- mem_dest  in  RADDR  MEM-stage destination
- mem_result  in  WIDTH  MEM-stage forwarded value
- wb_regWrite  in  1  WB-stage write enable
- wb_dest  in  RADDR  WB-stage destination
- wb_result  in  WIDTH  WB-stage forwarded value
- aluA, aluB  out  WIDTH  ALU operands (combinational from state and bypass)
- aluOp  out  4  ALU operation
- storeData  out  WIDTH  forwarded rt value for stores
- ex_valid, ex_regWrite, ex_memRead, ex_memWrite  out  1  registered control
- ex_dest  out  RADDR  registered destination
- ex_pc  out  WIDTH  registered PC
- loadUseHazard  out  1  ID must hold; a bubble is being inserted

Behaviour:
- Reset (async, rst_n=0): all registered state cleared to a bubble: valid/regWrite/memRead/memWrite=0, dest=0, pc=0, data=0, aluOp=`ALU_ADD`, selects=0. Outputs are therefore aluA=aluB=storeData=0 and aluOp=`ALU_ADD`.
- loadUseHazard (combinational) is 1 when all of the following hold:
  - ex_valid & ex_memRead & ex_dest≠0
  - ((in_useRs & in_rs==ex_dest) | (in_useRt & in_rt==ex_dest))
  - in_valid
- Edge update priority:
  - flush: load bubble.
  - else stall: hold, but refresh stored rs/rt data with current forwarded values, so WB retirement during a hold is not lost.
  - else loadUseHazard: load bubble.
  - else: load all in_* fields.
- Forwarding, rs and rt independently:
  - MEM hit when mem_regWrite & mem_dest≠0 & mem_dest==idx; value is mem_result.
  - else WB hit with the same rule on the wb_* signals; value is wb_result.
  - else the stored register value.
  - MEM has priority over WB. Index 0 is never forwarded.
- Operand select:
  - aluA: {27'b0, shamt} if shiftShamt; else {27'b0, rsF[4:0]} if shiftReg; else rsF.
  - aluB: imm if aluSrcImm & not a shift; else rtF.
  - shiftShamt and shiftReg are never set together; if both are set, shiftShamt wins.
  - storeData = rtF.
- Latency: one cycle from ID inputs to EX outputs. Bypass is zero-cycle (combinational).
- Simultaneous events:
  - flush with stall: flush wins.
  - flush with hazard: bubble, and loadUseHazard remains asserted combinationally.
  - stall with hazard: hold; the bubble is inserted on the first unstalled edge if the hazard persists.
- Reset mid-stall: contents discarded immediately, outputs go to bubble values.

Test Plan:
- Reset then release, stall=flush=0, in_valid=0 → ex_valid=0, aluOp=`ALU_ADD`, aluA=aluB=0.
- add rd=3, rs=1 (0x5), rt=2 (0x7), no hazards → next cycle aluA=0x5, aluB=0x7, ex_dest=3, ex_regWrite=1.
- Same instruction with mem_dest=1/mem_result=0xA and wb_dest=1/wb_result=0xB, both writing → aluA=0xA. Drop MEM → aluA=0xB. With dest=0 → no forward.
- sll shamt=4, rt=0x1 → aluA=0x4, aluB=0x1. sllv with rs=0xFFFFFF23 → aluA=0x3.
- lw dest=5 in EX; ID add using rs=5 → loadUseHazard=1, next edge ex_valid=0 & ex_regWrite=0. With ID inputs held, next edge loads the add and loadUseHazard=0.
- Stall for 2 cycles while wb writes rt=2 with 0x99 in cycle 1 only → after release aluB/storeData still 0x99. Assert flush together with stall → bubble loaded.
